// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory port between the I-cache and
// D-cache miss paths. The D-cache normally wins contention; a saturating
// starvation counter forces an I-cache grant once MAX_WAIT D-cache grants
// have been made while the I-cache was waiting.
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic              ic_done,
  output logic [DATA_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_ack,
  output logic              dc_done,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              busy
);
  localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, IC_BUSY, DC_BUSY} state_t;

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] starveCnt;
  logic [CNT_W-1:0] starveNext;
  logic             grantIc;
  logic             grantDc;
  logic             finish;

  // Arbitration, completion detection and starvation bookkeeping.
  always_comb begin
    stateNext  = state;
    starveNext = starveCnt;
    grantIc    = 1'b0;
    grantDc    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (dc_req && !(ic_req && starveCnt == MAX_CNT)) begin
          grantDc   = 1'b1;
          stateNext = DC_BUSY;
        end else if (ic_req) begin
          grantIc   = 1'b1;
          stateNext = IC_BUSY;
        end
      end
      IC_BUSY, DC_BUSY: begin
        // mem_en is high only in the launch cycle, where mem_done is ignored.
        if (!mem_en && mem_done) begin
          finish    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (grantIc) begin
      starveNext = '0;
    end else if (grantDc && ic_req) begin
      if (starveCnt != MAX_CNT) starveNext = starveCnt + CNT_W'(1);
    end else if (state == IDLE && !ic_req) begin
      starveNext = '0;
    end
  end

  // State and starvation counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      starveCnt <= '0;
    end else begin
      state     <= stateNext;
      starveCnt <= starveNext;
    end
  end

  // Launch strobes, held access registers and completion routing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_ack    <= 1'b0;
      dc_ack    <= 1'b0;
      ic_done   <= 1'b0;
      dc_done   <= 1'b0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
    end else begin
      mem_en  <= grantIc | grantDc;
      ic_ack  <= grantIc;
      dc_ack  <= grantDc;
      ic_done <= finish && (state == IC_BUSY);
      dc_done <= finish && (state == DC_BUSY);
      if (grantIc) begin
        mem_addr <= ic_addr;
        mem_wr   <= 1'b0;
      end else if (grantDc) begin
        mem_addr  <= dc_addr;
        mem_wr    <= dc_wr;
        mem_wdata <= dc_wdata;
      end
      if (finish && state == IC_BUSY) ic_rdata <= mem_rdata;
      if (finish && state == DC_BUSY && !mem_wr) dc_rdata <= mem_rdata;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration and completion rules.
module tb_mem_arbiter;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ic_req = 1'b0;
  logic [ADDR_W-1:0] ic_addr = '0;
  logic              ic_ack, ic_done;
  logic [DATA_W-1:0] ic_rdata;
  logic              dc_req = 1'b0;
  logic              dc_wr = 1'b0;
  logic [ADDR_W-1:0] dc_addr = '0;
  logic [DATA_W-1:0] dc_wdata = '0;
  logic              dc_ack, dc_done;
  logic [DATA_W-1:0] dc_rdata;
  logic              mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_done = 1'b0;
  logic              busy;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_done(dc_done), .dc_rdata(dc_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model state
  logic [DATA_W-1:0] tbMem [65536];
  int                memLat = 1;
  int                cd = 0;
  logic              lWr = 1'b0;
  logic [ADDR_W-1:0] lAddr = '0;

  logic [DATA_W-1:0] expIc = '0;
  logic [DATA_W-1:0] expDc = '0;

  // Memory responder: mem_done arrives memLat cycles after the launch cycle.
  task automatic memStep();
    mem_done  = 1'b0;
    mem_rdata = 16'($urandom);
    if (mem_en) begin
      cd    = memLat;
      lAddr = mem_addr;
      lWr   = mem_wr;
      if (mem_wr) tbMem[mem_addr] = mem_wdata;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mem_done = 1'b1;
        if (!lWr) mem_rdata = tbMem[lAddr];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    memStep();
  endtask

  task automatic waitAck(output int who);
    who = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ic_ack || dc_ack) begin
        who = (ic_ack ? 1 : 0) + (dc_ack ? 2 : 0);
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL drain busy=%b want 0", busy); end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({ic_ack, ic_done, dc_ack, dc_done, mem_en, mem_wr, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000000", {ic_ack, ic_done, dc_ack, dc_done, mem_en, mem_wr, busy});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 32'h0) begin
      errors++; $display("FAIL reset_mem got %h/%h want 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if ({ic_rdata, dc_rdata} !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h/%h want 0/0", ic_rdata, dc_rdata);
    end
    rst = 1'b0;
    expIc = '0;
    expDc = '0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%b want 0", busy); end
  endtask

  task automatic test_ic_read();
    int bad;
    memLat = 3;
    tbMem[16'h0040] = 16'hBEEF;
    ic_addr = 16'h0040;
    ic_req = 1'b1;
    tick();
    checks++;
    if ({ic_ack, dc_ack, mem_en, mem_wr, busy} !== 5'b10101) begin
      errors++; $display("FAIL ic_launch got %b want 10101", {ic_ack, dc_ack, mem_en, mem_wr, busy});
    end
    checks++;
    if (mem_addr !== 16'h0040) begin errors++; $display("FAIL ic_addr got %h want 0040", mem_addr); end
    ic_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy !== 1'b1 || ic_done !== 1'b0 || mem_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ic_wait bad_cycles=%0d want 0", bad); end
    tick();
    checks++;
    if ({ic_done, dc_done, busy} !== 3'b100) begin
      errors++; $display("FAIL ic_done got %b want 100", {ic_done, dc_done, busy});
    end
    checks++;
    if (ic_rdata !== 16'hBEEF) begin errors++; $display("FAIL ic_rdata got %h want beef", ic_rdata); end
    expIc = 16'hBEEF;
    tick();
    checks++;
    if (ic_done !== 1'b0) begin errors++; $display("FAIL ic_done_pulse got %b want 0", ic_done); end
  endtask

  task automatic test_dc_write_read();
    memLat = 1;
    dc_wr = 1'b1; dc_addr = 16'h1000; dc_wdata = 16'h1234; dc_req = 1'b1;
    tick();
    checks++;
    if ({dc_ack, ic_ack, mem_en, mem_wr, mem_addr, mem_wdata} !== {4'b1011, 16'h1000, 16'h1234}) begin
      errors++;
      $display("FAIL dc_wr_launch got %b %h %h want 1011 1000 1234", {dc_ack, ic_ack, mem_en, mem_wr}, mem_addr, mem_wdata);
    end
    dc_req = 1'b0;
    tick();
    tick();
    checks++;
    if (dc_done !== 1'b1 || dc_rdata !== expDc) begin
      errors++; $display("FAIL dc_wr_done got %b/%h want 1/%h", dc_done, dc_rdata, expDc);
    end
    dc_wr = 1'b0; dc_req = 1'b1;
    tick();
    checks++;
    if ({dc_ack, mem_en, mem_wr} !== 3'b110) begin
      errors++; $display("FAIL dc_rd_launch got %b want 110", {dc_ack, mem_en, mem_wr});
    end
    dc_req = 1'b0;
    tick();
    tick();
    checks++;
    if (dc_done !== 1'b1 || dc_rdata !== 16'h1234) begin
      errors++; $display("FAIL dc_rd_done got %b/%h want 1/1234", dc_done, dc_rdata);
    end
    expDc = 16'h1234;
  endtask

  task automatic test_starvation();
    int who, expWho;
    memLat = 1;
    ic_addr = 16'h0A00; dc_addr = 16'h0D00; dc_wr = 1'b1; dc_wdata = 16'h5555;
    ic_req = 1'b1; dc_req = 1'b1;
    for (int g = 0; g < 6; g++) begin
      waitAck(who);
      expWho = (g == 4) ? 1 : 2;
      checks++;
      if (who != expWho) begin errors++; $display("FAIL starve_grant%0d got %0d want %0d", g, who, expWho); end
      checks++;
      if (mem_wr !== (expWho == 2)) begin errors++; $display("FAIL starve_wr%0d got %b want %b", g, mem_wr, expWho == 2); end
    end
    ic_req = 1'b0; dc_req = 1'b0;
    drain();
  endtask

  task automatic test_withdraw();
    int who, bad;
    memLat = 3;
    dc_wr = 1'b0; dc_addr = 16'h2000; ic_addr = 16'h0B00;
    ic_req = 1'b1; dc_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      waitAck(who);
      checks++;
      if (who != 2) begin errors++; $display("FAIL wd_grant%0d got %0d want 2", g, who); end
    end
    ic_req = 1'b0; dc_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ic_ack || mem_en) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wd_no_launch launches=%0d want 0", bad); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wd_idle busy=%b want 0", busy); end
    ic_req = 1'b1; dc_req = 1'b1;
    waitAck(who);
    checks++;
    if (who != 2) begin errors++; $display("FAIL wd_cleared got %0d want 2", who); end
    ic_req = 1'b0; dc_req = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    int who, bad;
    memLat = 3;
    dc_wr = 1'b0; dc_addr = 16'h3000; dc_req = 1'b1;
    waitAck(who);
    checks++;
    if (who != 2) begin errors++; $display("FAIL rmid_grant got %0d want 2", who); end
    dc_req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({ic_ack, ic_done, dc_ack, dc_done, mem_en, mem_wr, busy} !== 7'b0) begin
      errors++;
      $display("FAIL rmid_ctrl got %b want 0000000", {ic_ack, ic_done, dc_ack, dc_done, mem_en, mem_wr, busy});
    end
    checks++;
    if ({mem_addr, mem_wdata, ic_rdata, dc_rdata} !== 64'h0) begin
      errors++; $display("FAIL rmid_data got %h %h %h %h want 0", mem_addr, mem_wdata, ic_rdata, dc_rdata);
    end
    tick();
    rst = 1'b0;
    expIc = '0;
    expDc = '0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dc_done || ic_done || busy || mem_en) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rmid_stale bad_cycles=%0d want 0", bad); end
    ic_addr = 16'h0C00; ic_req = 1'b1;
    tick();
    checks++;
    if (ic_ack !== 1'b1) begin errors++; $display("FAIL rmid_rearb ic_ack=%b want 1", ic_ack); end
    ic_req = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] q[$];
    logic [ADDR_W-1:0] a;
    int lastEn, launches, dones;
    lastEn = -1; launches = 0; dones = 0;
    memLat = 1;
    ic_addr = 16'($urandom);
    ic_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (mem_en) begin
        if (lastEn >= 0) begin
          checks++;
          if (c - lastEn != 3) begin errors++; $display("FAIL b2b_spacing got %0d want 3", c - lastEn); end
        end
        checks++;
        if (ic_ack !== 1'b1 || mem_addr !== ic_addr) begin
          errors++; $display("FAIL b2b_launch ack=%b addr=%h want 1/%h", ic_ack, mem_addr, ic_addr);
        end
        lastEn = c;
        launches++;
        q.push_back(ic_addr);
        ic_addr = 16'($urandom);
      end
      if (ic_done) begin
        dones++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_done got done with no launch want none");
        end else begin
          a = q.pop_front();
          if (ic_rdata !== tbMem[a]) begin
            errors++; $display("FAIL b2b_rdata addr=%h got %h want %h", a, ic_rdata, tbMem[a]);
          end
        end
      end
      if (c == 30) ic_req = 1'b0;
    end
    checks++;
    if (launches < 9 || dones != launches) begin
      errors++; $display("FAIL b2b_count launches=%0d dones=%0d want >=9 and equal", launches, dones);
    end
    drain();
  endtask

  task automatic test_random();
    int waitCnt, owner, who, expWho;
    bit free, lastDcWr, expIcD, expDcD;
    logic pIc, pDc, pDone, pDcWr;
    logic [ADDR_W-1:0] pIcA, pDcA;
    logic [DATA_W-1:0] pDcWd, pRd;
    waitCnt = 0; owner = 0; free = 1'b1; lastDcWr = 1'b0;
    ic_req = 1'b0; dc_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expIc = '0;
    expDc = '0;
    for (int c = 0; c < 3000; c++) begin
      memLat = $urandom_range(1, 4);
      pIc = ic_req; pDc = dc_req; pDone = mem_done; pRd = mem_rdata;
      pIcA = ic_addr; pDcA = dc_addr; pDcWr = dc_wr; pDcWd = dc_wdata;
      tick();
      who = (ic_ack ? 1 : 0) + (dc_ack ? 2 : 0);
      expWho = 0;
      if (free && (pIc || pDc)) expWho = (pDc && (!pIc || waitCnt < MAX_WAIT)) ? 2 : 1;
      checks++;
      if (who != expWho) begin errors++; $display("FAIL rnd_grant c=%0d got %0d want %0d", c, who, expWho); end
      checks++;
      if (mem_en !== (expWho != 0)) begin errors++; $display("FAIL rnd_en c=%0d got %b want %b", c, mem_en, expWho != 0); end
      if (expWho == 1) begin
        checks++;
        if ({mem_wr, mem_addr} !== {1'b0, pIcA}) begin
          errors++; $display("FAIL rnd_ic_cmd c=%0d got %b/%h want 0/%h", c, mem_wr, mem_addr, pIcA);
        end
        waitCnt = 0; owner = 1; free = 1'b0;
      end
      if (expWho == 2) begin
        checks++;
        if ({mem_wr, mem_addr} !== {pDcWr, pDcA} || (pDcWr && mem_wdata !== pDcWd)) begin
          errors++;
          $display("FAIL rnd_dc_cmd c=%0d got %b/%h/%h want %b/%h/%h", c, mem_wr, mem_addr, mem_wdata, pDcWr, pDcA, pDcWd);
        end
        if (pIc && waitCnt < MAX_WAIT) waitCnt++;
        owner = 2; free = 1'b0; lastDcWr = pDcWr;
      end
      expIcD = pDone && owner == 1;
      expDcD = pDone && owner == 2;
      if (pDone) begin
        if (owner == 1) expIc = pRd;
        else if (!lastDcWr) expDc = pRd;
        free = 1'b1;
      end
      checks++;
      if ({ic_done, dc_done} !== {expIcD, expDcD}) begin
        errors++; $display("FAIL rnd_done c=%0d got %b%b want %b%b", c, ic_done, dc_done, expIcD, expDcD);
      end
      checks++;
      if (ic_rdata !== expIc || dc_rdata !== expDc) begin
        errors++; $display("FAIL rnd_rdata c=%0d got %h/%h want %h/%h", c, ic_rdata, dc_rdata, expIc, expDc);
      end
      checks++;
      if (busy !== !free) begin errors++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, !free); end
      // Requesters hold until acked, then either drop or present a new request.
      if (ic_req && ic_ack) begin
        if ($urandom_range(0, 3) == 0) ic_addr = 16'($urandom_range(0, 31));
        else ic_req = 1'b0;
      end else if (!ic_req && $urandom_range(0, 2) == 0) begin
        ic_req = 1'b1; ic_addr = 16'($urandom_range(0, 31));
      end
      if (dc_req && dc_ack) begin
        if ($urandom_range(0, 3) == 0) begin
          dc_addr = 16'($urandom_range(0, 31)); dc_wr = 1'($urandom); dc_wdata = 16'($urandom);
        end else dc_req = 1'b0;
      end else if (!dc_req && $urandom_range(0, 2) == 0) begin
        dc_req = 1'b1; dc_addr = 16'($urandom_range(0, 31)); dc_wr = 1'($urandom); dc_wdata = 16'($urandom);
      end
    end
    ic_req = 1'b0; dc_req = 1'b0;
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) tbMem[i] = 16'($urandom);
    test_reset();
    test_ic_read();
    test_dc_write_read();
    test_starvation();
    test_withdraw();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single main-memory port between the instruction cache and the data cache miss paths. Sits between the cache controllers and the multi-cycle memory: accepts one read from the I-cache side and one read/write from the D-cache side, grants one at a time, launches the access, and routes completion and read data back to the winner. The D-cache has priority, with a starvation guard for the I-cache.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MAX_WAIT, 4, D-cache grants allowed while an I-cache request waits before the I-cache is forced next (≥1)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ic_req  in  1  I-cache read request, held until ic_ack
- ic_addr  in  ADDR_W  I-cache read address, stable while ic_req
- ic_ack  out  1  one-cycle pulse: I-cache request launched
- ic_done  out  1  one-cycle pulse: I-cache read complete, ic_rdata valid
- ic_rdata  out  DATA_W  I-cache read data, held until next ic_done
- dc_req  in  1  D-cache request, held until dc_ack
- dc_wr  in  1  1 = write, 0 = read
- dc_addr  in  ADDR_W  D-cache address
- dc_wdata  in  DATA_W  D-cache write data
- dc_ack  out  1  one-cycle pulse: D-cache request launched
- dc_done  out  1  one-cycle pulse: D-cache access complete, dc_rdata valid on reads
- dc_rdata  out  DATA_W  D-cache read data, held until next dc_done
- mem_en  out  1  one-cycle launch strobe to memory
- mem_wr  out  1  write qualifier for mem_en
- mem_addr  out  ADDR_W  registered access address, held through access
- mem_wdata  out  DATA_W  registered write data, held through access
- mem_rdata  in  DATA_W  memory read data, valid with mem_done
- mem_done  in  1  memory completion pulse
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, IC_BUSY, DC_BUSY.
- IDLE arbitration, evaluated every cycle:
  - both low → stay in IDLE
  - only one request high → grant it
  - both high → grant the D-cache, unless starve_cnt == MAX_WAIT, in which case grant the I-cache
- Grant: register addr/wdata/wr into mem_* outputs; enter the matching BUSY state.
- Grant cycle:
  - first BUSY cycle is the launch cycle: mem_en=1 and the matching ack=1 for exactly that cycle
  - I-cache grant forces mem_wr=0
- In BUSY (cycles after launch):
  - wait for mem_done
  - on mem_done: capture mem_rdata into the winner's rdata register (D-cache writes leave dc_rdata unchanged), pulse the winner's done next cycle, return to IDLE
- mem_done is ignored in IDLE and in the launch cycle. Memory guarantees that mem_done arrives no earlier than the cycle after mem_en.
- starve_cnt, a counter of width clog2(MAX_WAIT+1):
  - +1 on each D-cache grant made while ic_req is high, saturating at MAX_WAIT
  - cleared on an I-cache grant, or on any IDLE cycle with ic_req low
- Request withdrawal: dropping a request before its ack is legal. Nothing is launched for it.
- A request still high in the cycle after its ack is treated as a new request.
- No request queueing; requesters hold req. No timeout: BUSY waits indefinitely for mem_done.

## Timing
- Reset values:
  - state IDLE, starve_cnt 0
  - every output 0, including rdata registers and mem_addr/mem_wdata
- Reset mid-access: immediate return to IDLE, outputs to 0. A stale mem_done after reset is ignored.
- Request high at cycle N in IDLE → mem_en/ack at N+1.
- mem_done at cycle M (M ≥ N+2) → done pulse and updated rdata at M+1. State is IDLE at M+1.
- A request pending at M+1 is arbitrated at M+1 and launched at M+2.
- Minimum turnaround: 3 cycles per access with a 1-cycle memory.
- ic_done and dc_done are never high in the same cycle. Exactly one ack per launch.

## Test plan
- Single I-cache read:
  - stimulus: ic_req, addr 0x0040; mem_done 3 cycles after launch with 0xBEEF
  - required: ic_ack 1 cycle after req; mem_wr=0; ic_done 4 cycles after launch; ic_rdata=0xBEEF; busy high throughout
- D-cache write then read:
  - write: addr 0x1000, data 0x1234 → mem_wr=1, mem_wdata=0x1234, dc_done, dc_rdata unchanged
  - read: same address, mem_rdata=0x1234 → dc_rdata=0x1234
- Simultaneous requests, MAX_WAIT=4:
  - stimulus: both high; dc_req re-raised immediately each time
  - required: D-cache wins 4 grants, 5th grant goes to the I-cache (starve_cnt 4→0); next contention goes to the D-cache again
- Withdrawal:
  - stimulus: ic_req high during a D-cache access, dropped before IDLE
  - required: no ic_ack, no mem_en for it; starve_cnt cleared
- Reset mid-access:
  - stimulus: assert rst during DC_BUSY; mem_done arrives after release
  - required: all outputs 0 at once; no dc_done; state IDLE
- Back-to-back:
  - stimulus: 1-cycle memory, ic_req held high
  - required: mem_en every 3 cycles, one ic_done per launch, rdata correct per access
